// File: rtl/uart_cpu_oci_trace_capture.sv
// Purpose: capture OCI trace words into a small buffer, freeze on request, then drain to a consumer.
// Latency: a write shows in level one cycle later; rd_data presents the head entry with zero latency.
// Backpressure: rd_ready stalls the drain; a full buffer drops the newest word (or, with
//   OCI_TRACE_WRAP_EN defined, overwrites the oldest). Either way ovf_count counts the loss.
module uart_cpu_oci_trace_capture #(
  parameter int DATA_W = 30,
  parameter int CNT_W  = 4,
  parameter int DEPTH  = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [DATA_W-1:0]       dct_buffer,
  input  logic [CNT_W-1:0]        dct_count,
  input  logic                    dct_valid,
  input  logic                    test_ending,
  input  logic                    test_has_ended,
  input  logic                    rd_ready,
  output logic                    rd_valid,
  output logic [CNT_W+DATA_W-1:0] rd_data,
  output logic [$clog2(DEPTH):0]  level,
  output logic [7:0]              ovf_count,
  output logic [2:0]              state,
  output logic                    done
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = CNT_W + DATA_W;
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    FREEZE  = 3'd2,
    DRAIN   = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level_q;
  logic [7:0]    ovf_q;

  logic write_window;
  logic wr_qual;
  logic full;
  logic empty;
  logic do_store;
  logic wr_overwrite;
  logic ovf_evt;
  logic do_pop;

  // Qualify writes and decide between storing, dropping, or overwriting when full.
  always_comb begin
    full         = (level_q == LVL_FULL);
    empty        = (level_q == '0);
    write_window = (state_q == IDLE) || (state_q == CAPTURE);
    wr_qual      = write_window && dct_valid && (dct_count != '0);
    ovf_evt      = wr_qual && full;
`ifdef OCI_TRACE_WRAP_EN
    // Full buffer keeps the freshest history: the oldest entry is sacrificed.
    do_store     = wr_qual;
    wr_overwrite = wr_qual && full;
`else
    // Full buffer keeps the earliest history: the new word is dropped.
    do_store     = wr_qual && !full;
    wr_overwrite = 1'b0;
`endif
    do_pop       = rd_valid && rd_ready;
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_store) begin
      mem[wr_ptr] <= {dct_count, dct_buffer};
    end
  end

  // Pointers and occupancy. Stores happen only before DRAIN and pops only in DRAIN,
  // so the two never coincide.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (do_store) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop || wr_overwrite) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_store && !wr_overwrite) begin
        level_q <= level_q + 1'b1;
      end else if (do_pop) begin
        level_q <= level_q - 1'b1;
      end
    end
  end

  // Lost-word counter, saturating so a long overflow never reads as a small number.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= '0;
    end else if (ovf_evt && (ovf_q != 8'hFF)) begin
      ovf_q <= ovf_q + 8'd1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; test_has_ended outranks test_ending so a late stop goes straight to DRAIN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (test_has_ended) begin
          state_d = DRAIN;
        end else if (test_ending) begin
          state_d = FREEZE;
        end else if (wr_qual) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (test_has_ended) begin
          state_d = DRAIN;
        end else if (test_ending) begin
          state_d = FREEZE;
        end
      end
      FREEZE: begin
        if (test_has_ended) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (empty) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Head entry is always visible (zero when empty); it is only offered during DRAIN.
  always_comb begin
    rd_valid  = (state_q == DRAIN) && !empty;
    rd_data   = empty ? '0 : mem[rd_ptr];
    level     = level_q;
    ovf_count = ovf_q;
    state     = state_q;
    done      = (state_q == DONE);
  end

endmodule

// File: tb/tb_uart_cpu_oci_trace_capture.sv
module tb_uart_cpu_oci_trace_capture;
  localparam int DATA_W = 30;
  localparam int CNT_W  = 4;
  localparam int DEPTH  = 16;
  localparam int EW     = DATA_W + CNT_W;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [DATA_W-1:0] dct_buffer = '0;
  logic [CNT_W-1:0]  dct_count = '0;
  logic              dct_valid = 1'b0;
  logic              test_ending = 1'b0;
  logic              test_has_ended = 1'b0;
  logic              rd_ready = 1'b0;
  logic              rd_valid;
  logic [EW-1:0]     rd_data;
  logic [4:0]        level;
  logic [7:0]        ovf_count;
  logic [2:0]        state;
  logic              done;

  uart_cpu_oci_trace_capture #(.DATA_W(DATA_W), .CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .dct_buffer(dct_buffer), .dct_count(dct_count),
    .dct_valid(dct_valid), .test_ending(test_ending), .test_has_ended(test_has_ended),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data), .level(level),
    .ovf_count(ovf_count), .state(state), .done(done)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of stored entries, the phase code and the loss counter.
  logic [EW-1:0] q[$];
  int ph  = 0;
  int ovf = 0;
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [EW-1:0] head;
    head = '0;
    if (q.size() != 0) head = q[0];
    chk("state", 64'(state), 64'(ph));
    chk("level", 64'(level), 64'(q.size()));
    chk("ovf_count", 64'(ovf_count), 64'(ovf));
    chk("done", 64'(done), 64'(ph == 4));
    chk("rd_valid", 64'(rd_valid), 64'((ph == 3) && (q.size() != 0)));
    chk("rd_data", 64'(rd_data), 64'(head));
  endtask

  // Apply the behavioural rules for one clock edge using the inputs currently driven.
  task automatic model_edge();
    bit wq, pp;
    int nph;
    wq  = ((ph == 0) || (ph == 1)) && dct_valid && (dct_count != 0);
    pp  = (ph == 3) && (q.size() != 0) && rd_ready;
    nph = ph;
    if (ph == 0 || ph == 1) begin
      if (test_has_ended) nph = 3;
      else if (test_ending) nph = 2;
      else if (wq) nph = 1;
    end else if (ph == 2) begin
      if (test_has_ended) nph = 3;
    end else if (ph == 3) begin
      if (q.size() == 0) nph = 4;
    end
    if (wq) begin
      if (q.size() < DEPTH) begin
        q.push_back({dct_count, dct_buffer});
      end else begin
`ifdef OCI_TRACE_WRAP_EN
        void'(q.pop_front());
        q.push_back({dct_count, dct_buffer});
`endif
        if (ovf < 255) ovf++;
      end
    end
    if (pp) void'(q.pop_front());
    ph = nph;
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(input bit v, input logic [CNT_W-1:0] c, input logic [DATA_W-1:0] b,
                       input bit te, input bit he, input bit rr);
    dct_valid = v; dct_count = c; dct_buffer = b;
    test_ending = te; test_has_ended = he; rd_ready = rr;
  endtask

  task automatic idle();
    drive(0, '0, '0, 0, 0, 0);
  endtask

  // Asynchronous reset: outputs must clear before any clock edge arrives.
  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    #1;
    q.delete(); ph = 0; ovf = 0;
    check_all();
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    idle();
    cycle();
  endtask

  task automatic drain_until_done(input int budget, input bit random_ready);
    for (int i = 0; i < budget && ph != 4; i++) begin
      drive(0, '0, '0, 0, 0, random_ready ? bit'($urandom_range(0, 1)) : 1'b1);
      cycle();
    end
    chk("done_reached", 64'(done), 64'd1);
  endtask

  initial begin
    // Reset state at time zero.
    #1;
    check_all();
    @(posedge clk); #3; reset_n = 1'b1; idle(); cycle();

    // Three words then drain: counts come back 1,2,3; done two cycles after the last pop.
    for (int k = 1; k <= 3; k++) begin
      drive(1, CNT_W'(k), DATA_W'($urandom), 0, 0, 1);
      cycle();
    end
    drive(0, '0, '0, 0, 1, 1);
    cycle();
    for (int k = 1; k <= 3; k++) begin
      chk("r037_count", 64'(rd_data[EW-1:DATA_W]), 64'(k));
      drive(0, '0, '0, 0, 0, 1);
      cycle();
    end
    chk("r037_level0", 64'(level), 64'd0);
    chk("r037_not_done_yet", 64'(done), 64'd0);
    cycle();
    chk("r037_done", 64'(done), 64'd1);

    // Twenty words into a sixteen-entry buffer.
    do_reset();
    for (int j = 1; j <= 20; j++) begin
      drive(1, CNT_W'((j % 15) + 1), DATA_W'(j), 0, 0, 0);
      cycle();
    end
    idle(); cycle();
    chk("r038_level", 64'(level), 64'd16);
    chk("r038_ovf", 64'(ovf_count), 64'd4);
    drive(0, '0, '0, 0, 1, 0);
    cycle();
    for (int i = 0; i < 16; i++) begin
`ifdef OCI_TRACE_WRAP_EN
      chk("r039_word", 64'(rd_data[DATA_W-1:0]), 64'(5 + i));
`else
      chk("r038_word", 64'(rd_data[DATA_W-1:0]), 64'(1 + i));
`endif
      drive(0, '0, '0, 0, 0, 1);
      cycle();
    end
    drain_until_done(4, 0);

    // Stop request with a same-cycle word; later words in FREEZE are ignored.
    do_reset();
    drive(1, 4'd3, DATA_W'($urandom), 1, 0, 1);
    cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1, CNT_W'($urandom_range(1, 15)), DATA_W'($urandom), 0, 0, 1);
      cycle();
    end
    chk("r040_level", 64'(level), 64'd1);
    chk("r040_frozen_rd_valid", 64'(rd_valid), 64'd0);
    drive(0, '0, '0, 0, 1, 1);
    cycle();
    chk("r040_drain_rd_valid", 64'(rd_valid), 64'd1);
    drain_until_done(6, 0);

    // Randomised rounds with occasional stop requests and random consumer stalls.
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int i = 0; i < 300; i++) begin
        drive(($urandom_range(0, 3) != 0), CNT_W'($urandom), DATA_W'($urandom),
              ($urandom_range(0, 59) == 0), ($urandom_range(0, 89) == 0),
              bit'($urandom_range(0, 1)));
        cycle();
      end
      drive(0, '0, '0, 0, 1, 1);
      cycle();
      drain_until_done(200, 1);
    end

    // Reset during DRAIN with seven entries stored.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(1, CNT_W'($urandom_range(1, 15)), DATA_W'($urandom), 0, 0, 0);
      cycle();
    end
    drive(0, '0, '0, 0, 1, 0);
    cycle();
    idle(); cycle();
    chk("r041_level7", 64'(level), 64'd7);
    chk("r041_in_drain", 64'(state), 64'd3);
    do_reset();
    chk("r041_level_after", 64'(level), 64'd0);

    // Heavy overflow saturates the loss counter.
    for (int i = 0; i < 320; i++) begin
      drive(1, CNT_W'($urandom_range(1, 15)), DATA_W'($urandom), 0, 0, 0);
      cycle();
    end
    chk("r042_ovf_sat", 64'(ovf_count), 64'd255);
    chk("r042_level", 64'(level), 64'd16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/uart_cpu_oci_trace_capture.md
UART_CPU_OCI_TRACE_CAPTURE -- requirements
Module: uart_cpu_oci_trace_capture

Interface
REQ-001 Parameter DATA_W, default 30, width of one trace word (dct_buffer) SHALL be DATA_W.
REQ-002 Parameter CNT_W, default 4, width of the record-count field SHALL be CNT_W.
REQ-003 Parameter DEPTH, default 16, number of buffer entries; power of two, minimum 2; AW = log2(DEPTH).
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset_n  in  1  reset, asynchronous assertion, active-low.
REQ-006 dct_buffer  in  DATA_W  trace word from the OCI.
REQ-007 dct_count  in  CNT_W  number of valid records in dct_buffer.
REQ-008 dct_valid  in  1  one-cycle strobe qualifying dct_buffer/dct_count.
REQ-009 test_ending  in  1  request to stop capture.
REQ-010 test_has_ended  in  1  request to start drain.
REQ-011 rd_ready  in  1  consumer accepts rd_data.
REQ-012 rd_valid  out  1  rd_data holds an entry.
REQ-013 rd_data  out  CNT_W+DATA_W  entry at the head, packed as {count, buffer}.
REQ-014 level  out  AW+1  number of stored entries, 0..DEPTH.
REQ-015 ovf_count  out  8  number of lost or overwritten entries, saturating.
REQ-016 state  out  3  current FSM state code.
REQ-017 done  out  1  high in DONE.

Function
REQ-018 The FSM SHALL have the states IDLE=0, CAPTURE=1, FREEZE=2, DRAIN=3 and DONE=4; the unused codes 5-7 SHALL go to IDLE on the next clock.
REQ-019 IDLE->CAPTURE on dct_valid with dct_count!=0, and that word SHALL be written in the same cycle.
REQ-020 A word SHALL be written only in IDLE or CAPTURE, only when dct_valid=1, and only when dct_count!=0; words with dct_count=0 SHALL be discarded without affecting ovf_count.
REQ-021 A write SHALL store {dct_count, dct_buffer} at the write pointer; level SHALL increment 1 cycle later.
REQ-022 On test_ending in IDLE or CAPTURE, the FSM SHALL go to FREEZE next cycle, and a valid word in the same cycle SHALL still be written.
REQ-023 In FREEZE, writes SHALL be ignored, rd_valid SHALL be 0, and test_has_ended SHALL move the FSM to DRAIN.
REQ-024 On test_has_ended in IDLE or CAPTURE (with or without test_ending), the FSM SHALL go directly to DRAIN, and a same-cycle valid word SHALL still be written.
REQ-025 In DRAIN, rd_valid SHALL equal (level!=0), rd_data SHALL present the head entry with zero latency, and rd_valid&rd_ready SHALL pop one entry.
REQ-026 In DRAIN with level=0, the FSM SHALL go to DONE on the next clock; DONE is sticky until reset, with no writes and no reads.
REQ-027 Outside DRAIN, rd_valid SHALL be 0, and rd_data SHALL hold the head entry, or 0 when empty.
REQ-028 Read and write pointers SHALL be AW bits and wrap modulo DEPTH without any special case.
REQ-029 When full (level=DEPTH) and a word qualifies, the default behaviour SHALL drop the new word, ovf_count SHALL increment, and level SHALL be unchanged.
REQ-030 ovf_count SHALL saturate at 255 and never wrap.

Reset
REQ-031 Assertion of reset_n=0 SHALL immediately force state=IDLE, both pointers=0, level=0, ovf_count=0, rd_valid=0, rd_data=0 and done=0.
REQ-032 Reset mid-capture or mid-drain SHALL discard all stored entries.
REQ-033 Storage array contents SHALL NOT need to be reset.
REQ-034 Reset release SHALL take effect on the first clock edge after reset_n rises.

Configuration
REQ-035 With OCI_TRACE_WRAP_EN defined, a qualifying write while full SHALL overwrite the oldest entry and advance the read pointer, level SHALL stay DEPTH, and ovf_count SHALL increment (saturating).
REQ-036 Without OCI_TRACE_WRAP_EN, the drop-newest behaviour of REQ-029 SHALL apply.

Verification
REQ-037 Write 3 words (count=1,2,3), then test_has_ended, with rd_ready=1 -> rd_data counts 1,2,3 in order; level 3->0; done=1 two cycles after the last pop.
REQ-038 Write 20 words with DEPTH=16 and no macro -> level=16 and ovf_count=4; drain returns words 1..16.
REQ-039 Run REQ-038 with OCI_TRACE_WRAP_EN -> ovf_count=4; drain returns words 5..20.
REQ-040 test_ending together with a valid word, then 3 more valid words in FREEZE -> only the first word is stored (level=1), and rd_valid=0 until test_has_ended.
REQ-041 Assert reset_n=0 at level=7 during DRAIN -> all outputs are 0 asynchronously, and state=IDLE.
REQ-042 Write 300 words into a full buffer -> ovf_count holds at 255.
